// File: rtl/sram_model.sv
// Pin-level responder for the external asynchronous-style SRAM bus: byte-lane writes,
// fixed-latency registered reads. Define SRAM_MODEL_CHECK_EN to enable the protocol checker.
module sram_model #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 18,
  parameter int READ_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_OE_N,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  output logic              rd_valid,
  output logic [7:0]        err_count,
  output logic [1:0]        dbg_state
);

  localparam int HALF = DATA_W / 2;
  localparam logic [3:0] LAT_LOAD = 4'(READ_LAT - 1);
  localparam bit LAT_ONE = (READ_LAT == 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              ub_q;
  logic              lb_q;
  logic [DATA_W-1:0] dout_q;
  logic              drive_hi;
  logic              drive_lo;

  logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

  logic                  wr_cyc;
  logic                  rd_req;
  logic                  addr_chg;
  logic [DEPTH_LOG2-1:0] bus_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;

  // Handshake: a write (CE_N=0, WE_N=0) always wins; a read request is
  // CE_N=0, WE_N=1, OE_N=0 held with a stable address until rd_valid.
  assign wr_cyc   = !SRAM_CE_N && !SRAM_WE_N;
  assign rd_req   = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign addr_chg = (SRAM_ADDR != addr_q);
  assign bus_idx  = SRAM_ADDR[DEPTH_LOG2-1:0];
  assign rd_idx   = addr_q[DEPTH_LOG2-1:0];

  // Storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_cyc) begin
      if (!SRAM_UB_N) mem[bus_idx][DATA_W-1:HALF] <= SRAM_DQ[DATA_W-1:HALF];
      if (!SRAM_LB_N) mem[bus_idx][HALF-1:0]      <= SRAM_DQ[HALF-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      addr_q   <= '0;
      ub_q     <= 1'b0;
      lb_q     <= 1'b0;
      dout_q   <= '0;
      drive_hi <= 1'b0;
      drive_lo <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      drive_hi <= 1'b0;
      drive_lo <= 1'b0;
      rd_valid <= 1'b0;
      if (wr_cyc || !rd_req) begin
        state <= IDLE;
      end else if (state == IDLE || addr_chg) begin
        // New read or address change mid-read: relatch and restart latency.
        addr_q  <= SRAM_ADDR;
        ub_q    <= !SRAM_UB_N;
        lb_q    <= !SRAM_LB_N;
        lat_cnt <= LAT_LOAD;
        if (LAT_ONE) begin
          dout_q   <= mem[bus_idx];
          state    <= RD_DRIVE;
          drive_hi <= !SRAM_UB_N;
          drive_lo <= !SRAM_LB_N;
          rd_valid <= 1'b1;
        end else begin
          state <= RD_WAIT;
        end
      end else if (state == RD_WAIT) begin
        if (lat_cnt == 4'd0) begin
          dout_q   <= mem[rd_idx];
          state    <= RD_DRIVE;
          drive_hi <= ub_q;
          drive_lo <= lb_q;
          rd_valid <= 1'b1;
        end else begin
          lat_cnt <= lat_cnt - 4'd1;
        end
      end else if (state == RD_DRIVE) begin
        drive_hi <= ub_q;
        drive_lo <= lb_q;
        rd_valid <= 1'b1;
      end else begin
        state <= IDLE;
      end
    end
  end

  // Bus enables come straight from registers; no input-to-DQ path.
  assign SRAM_DQ[DATA_W-1:HALF] = drive_hi ? dout_q[DATA_W-1:HALF] : {HALF{1'bz}};
  assign SRAM_DQ[HALF-1:0]      = drive_lo ? dout_q[HALF-1:0]      : {HALF{1'bz}};
  assign dbg_state = state;

`ifdef SRAM_MODEL_CHECK_EN
  logic viol;

  assign viol = (!SRAM_CE_N && !SRAM_WE_N && !SRAM_OE_N)
             || (wr_cyc && state == RD_DRIVE)
             || (rd_req && state == RD_WAIT && addr_chg)
             || (!SRAM_CE_N && SRAM_UB_N && SRAM_LB_N);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= 8'd0;
    end else if (viol && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_sram_model.sv
// Directed bench for sram_model (READ_LAT=2, DEPTH_LOG2=10); the pulled-up bus
// reads 0xFF on any lane nobody drives.
module tb_sram_model;

`ifdef SRAM_MODEL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [15:0] REL = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] addr = '0;
  logic        ce_n = 1'b1;
  logic        we_n = 1'b1;
  logic        oe_n = 1'b1;
  logic        ub_n = 1'b0;
  logic        lb_n = 1'b0;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_dq = '0;
  wire  [15:0] dq;
  logic        rd_valid;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_err = 0;

  assign dq = tb_oe ? tb_dq : 16'hzzzz;
  pullup pu (dq);

  sram_model #(.ADDR_W(18), .DATA_W(16), .DEPTH_LOG2(10), .READ_LAT(2)) dut (
    .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq),
    .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .rd_valid(rd_valid), .err_count(err_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bump_err();
    if (CHK && exp_err < 255) exp_err++;
  endtask

  task automatic idle_bus();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    ub_n = 1'b0; lb_n = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
    addr = a; tb_dq = d; tb_oe = 1'b1;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = ub; lb_n = lb;
    tick();
    idle_bus();
  endtask

  // Samples the read at edge k, then checks Z at k and k+1 and data at k+2.
  task automatic rd(input string tag, input logic [17:0] a, input logic ub, input logic lb,
                    input logic [15:0] exp);
    addr = a; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = ub; lb_n = lb; tb_oe = 1'b0;
    tick();
    check({tag, "_z0"}, dq, REL);
    check({tag, "_v0"}, rd_valid, 0);
    tick();
    check({tag, "_z1"}, dq, REL);
    tick();
    check({tag, "_dq"}, dq, exp);
    check({tag, "_vld"}, rd_valid, 1);
  endtask

  task automatic end_rd();
    idle_bus();
    tick();
  endtask

  initial begin
    idle_bus();
    tick(3);
    check("rst_dq", dq, REL);
    check("rst_vld", rd_valid, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;
    tick();
    check("rst_err", err_count, 0);

    // Full write then lane-masked writes and reads
    wr(18'h00010, 16'hBEEF, 1'b0, 1'b0);
    rd("rd_beef", 18'h00010, 1'b0, 1'b0, 16'hBEEF);
    end_rd();
    check("rel_dq", dq, REL);
    check("rel_vld", rd_valid, 0);
    wr(18'h00010, 16'h12AA, 1'b0, 1'b1);
    rd("rd_ub", 18'h00010, 1'b0, 1'b0, 16'h12EF);
    end_rd();
    rd("rd_lbonly", 18'h00010, 1'b1, 1'b0, 16'hFFEF);
    end_rd();

    // Address change during RD_WAIT restarts latency
    wr(18'h00001, 16'h1111, 1'b0, 1'b0);
    wr(18'h00002, 16'h2222, 1'b0, 1'b0);
    addr = 18'h00001; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    tick();
    addr = 18'h00002;
    tick();
    bump_err();
    check("chg_z0", dq, REL);
    tick();
    check("chg_z1", dq, REL);
    check("chg_v1", rd_valid, 0);
    tick();
    check("chg_dq", dq, 16'h2222);
    check("chg_vld", rd_valid, 1);
    check("chg_err", err_count, exp_err);
    end_rd();

    // Reset mid-RD_WAIT and mid-RD_DRIVE
    addr = 18'h00010; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rstw_dq", dq, REL);
    check("rstw_vld", rd_valid, 0);
    check("rstw_err", err_count, 0);
    exp_err = 0;
    idle_bus();
    tick();
    rst = 1'b1;
    tick();
    rd("rd_keep", 18'h00010, 1'b0, 1'b0, 16'h12EF);
    rst = 1'b0;
    #1;
    check("rstd_dq", dq, REL);
    check("rstd_vld", rd_valid, 0);
    idle_bus();
    tick();
    rst = 1'b1;
    tick();

    // Write followed immediately by a read of the same word, then back-to-back reads
    wr(18'h00020, 16'h3456, 1'b0, 1'b0);
    rd("rd_wr2rd", 18'h00020, 1'b0, 1'b0, 16'h3456);
    rd("rd_b2b1", 18'h00001, 1'b0, 1'b0, 16'h1111);
    rd("rd_b2b2", 18'h00002, 1'b0, 1'b0, 16'h2222);
    check("b2b_err", err_count, exp_err);

    // Write while driving aborts the read
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    tick();
    bump_err();
    check("wabort_vld", rd_valid, 0);
    check("wabort_dq", dq, REL);
    check("wabort_err", err_count, exp_err);
    idle_bus();
    tick();

    // Active cycle with no lane enabled
    addr = 18'h00005; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = 1'b1; lb_n = 1'b1;
    tick();
    bump_err();
    end_rd();
    check("nolane_err", err_count, exp_err);

    // Aliasing above DEPTH_LOG2
    wr(18'h3FFFF, 16'h5A5A, 1'b0, 1'b0);
    rd("alias_a", 18'h003FF, 1'b0, 1'b0, 16'h5A5A);
    end_rd();
    wr(18'h003FF, 16'h6B6B, 1'b0, 1'b0);
    rd("alias_b", 18'h3FFFF, 1'b0, 1'b0, 16'h6B6B);
    end_rd();

    // WE_N and OE_N low together: write wins, checker saturates
    addr = 18'h00030; tb_dq = 16'h7C7C; tb_oe = 1'b1;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      bump_err();
    end
    check("cont_vld", rd_valid, 0);
    check("cont_state", dbg_state, 0);
    check("cont_err", err_count, exp_err);
    idle_bus();
    tick();
    check("cont_rel", dq, REL);
    rd("rd_cont", 18'h00030, 1'b0, 1'b0, 16'h7C7C);
    end_rd();
    check("final_err", err_count, exp_err);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
